seq_mult_shift_add: RTL and testbench
=====================================

// Module: seq_mult_shift_add
// PURPOSE
//  Iterative shift-add multiplier, the sequential stage that consumes the 1-bit adder cells of the mult package.
//  One partial-product add and one right shift per clock: WIDTH x WIDTH -> 2*WIDTH product.
//  Sits between the ALU operand registers and the HI/LO result registers.
//  Uses a START/BUSY/DONE handshake. Supports signed (two's complement) and unsigned operands.
// PARAMETERS
//  WIDTH   32   operand width in bits; product is 2*WIDTH. Legal range 4..64.
// PORTS
//  CLK     in   1        rising-edge clock
//  RST     in   1        reset; synchronous, active-high
//  START   in   1        request; sampled only in IDLE or DONE
//  SGN     in   1        1 = signed operands, 0 = unsigned; sampled with START
//  A       in   WIDTH    multiplicand; sampled with START
//  B       in   WIDTH    multiplier; sampled with START
//  HI      out  WIDTH    product[2*WIDTH-1:WIDTH]
//  LO      out  WIDTH    product[WIDTH-1:0]
//  BUSY    out  1        high while iterating
//  DONE    out  1        one-cycle pulse; HI/LO valid from this cycle
// BEHAVIOUR
//  Reset (RST=1 at a posedge): state=IDLE; HI=0, LO=0, BUSY=0, DONE=0; counter and datapath regs cleared.
//  Reset has priority over START and applies mid-operation; the partial result is discarded.
//  States: IDLE -> BUSY -> FIX -> DONE -> (IDLE | BUSY).
//  IDLE:
//   - START=1 -> latch operands and go to BUSY, count=0.
//   - If SGN=1, latch magnitudes |A| and |B|; neg = A[msb]^B[msb].
//   - If SGN=0, latch A and B as-is; neg = 0.
//   - Working regs: MC = |A|; {ACC(WIDTH+1), MQ(WIDTH)} = {0, |B|}.
//  BUSY, each clock:
//   - If MQ[0] = 1, sum = ACC + MC, else sum = ACC. sum is WIDTH+1 bits, carry kept.
//   - {ACC, MQ} <= {sum, MQ} >> 1, with zero fill.
//   - count++; after WIDTH iterations go to FIX.
//  FIX (one cycle):
//   - P = {ACC[WIDTH-1:0], MQ}; if neg, P = ~P + 1 (full 2*WIDTH-bit negate).
//   - {HI, LO} <= P; go to DONE.
//  DONE:
//   - DONE=1 for exactly this cycle.
//   - START=1 -> accept a new operation exactly as in IDLE (back-to-back); otherwise go to IDLE.
//  Latency: START sampled at edge E0; BUSY=1 after E0 through edge E0+WIDTH.
//   HI/LO update and DONE=1 after edge E0+WIDTH+1. Initiation interval is WIDTH+2 clocks.
//  START in BUSY or FIX is ignored: no queueing, no error.
//  A, B and SGN may change freely after the sampling edge.
//  HI and LO hold the last product until the next FIX or reset; they do not change during BUSY.
//  Arithmetic:
//   - |x| of the most-negative value is 2^(WIDTH-1), which is representable unsigned in WIDTH bits.
//   - Every signed product fits in 2*WIDTH bits; no overflow flag.
//   - Zero operand: the product is 0 and neg is ignored (negating 0 yields 0).
// TESTING (WIDTH=32)
//  1. Unsigned 5*7, START one cycle
//     -> HI=0, LO=0x00000023; DONE pulses 33 clocks after the sampling edge; BUSY high for 32 clocks.
//  2. Unsigned 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
//  3. Signed -3*4 -> HI=0xFFFFFFFF, LO=0xFFFFFFF4.
//     Signed 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
//  4. START pulsed at BUSY clock 5 with different A/B -> ignored, first result unchanged.
//     START held in the DONE cycle -> second op accepted, DONE again WIDTH+2 clocks later.
//  5. RST at BUSY clock 10 -> next cycle HI=LO=0, BUSY=DONE=0.
//     Subsequent 6*-7 signed -> LO=0xFFFFFFD6, HI=0xFFFFFFFF.
//  6. Random 1000 ops, SGN random, checked against a behavioural $signed/unsigned multiply.
//     Covers corner operands 0, 1, -1, max and min.

Source files
------------

// File: rtl/seq_mult_shift_add.sv
// Iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product.
// Each clock adds one partial product and shifts right. Signed operands are
// reduced to magnitudes on entry, and the sign is reapplied in a single FIX cycle.
module seq_mult_shift_add #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SGN,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   mc_q, mc_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]   mq_q, mq_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   shifted;
    logic [2*WIDTH-1:0] prod_raw;
    logic [2*WIDTH-1:0] prod;

    // Next-state, iteration datapath and result formation
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mc_d    = mc_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        a_mag    = (SGN && A[WIDTH-1]) ? -A : A;
        b_mag    = (SGN && B[WIDTH-1]) ? -B : B;
        sum      = mq_q[0] ? (acc_q + {1'b0, mc_q}) : acc_q;
        shifted  = {sum, mq_q} >> 1;
        prod_raw = {acc_q[WIDTH-1:0], mq_q};
        prod     = neg_q ? -prod_raw : prod_raw;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    mc_d    = a_mag;
                    acc_d   = '0;
                    mq_d    = b_mag;
                    neg_d   = SGN & (A[WIDTH-1] ^ B[WIDTH-1]);
                    count_d = '0;
                    state_d = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                acc_d   = shifted[2*WIDTH:WIDTH];
                mq_d    = shifted[WIDTH-1:0];
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                hi_d    = prod[2*WIDTH-1:WIDTH];
                lo_d    = prod[WIDTH-1:0];
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            count_q <= '0;
            mc_q    <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mc_q    <= mc_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign HI   = hi_q;
    assign LO   = lo_q;
    assign BUSY = (state_q == S_BUSY);
    assign DONE = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Self-checking bench for seq_mult_shift_add at WIDTH=32.
// A timing-level reference model tracks when each accepted operation must
// finish and what its product must be. Directed cases pin literal results.
module tb_seq_mult_shift_add;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST;
    logic         START;
    logic         SGN;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] HI;
    logic [W-1:0] LO;
    logic         BUSY;
    logic         DONE;

    int total = 0;
    int bad   = 0;

    int           cyc = 0;
    int           op_start = 0;
    bit           have_op = 1'b0;
    bit           check_en = 1'b0;
    logic [2*W-1:0] pending  = '0;
    logic [2*W-1:0] exp_prod = '0;
    bit           exp_busy = 1'b0;
    bit           exp_done = 1'b0;

    seq_mult_shift_add #(.WIDTH(W)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .START(START),
        .SGN  (SGN),
        .A    (A),
        .B    (B),
        .HI   (HI),
        .LO   (LO),
        .BUSY (BUSY),
        .DONE (DONE)
    );

    // Free-running clock
    always #5 CLK = ~CLK;

    function automatic logic [2*W-1:0] refProduct(input logic s, input logic [W-1:0] a,
                                                  input logic [W-1:0] b);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        if (s) begin
            sa = $signed({{W{a[W-1]}}, a});
            sb = $signed({{W{b[W-1]}}, b});
            return sa * sb;
        end
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    function automatic logic [W-1:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [2*W-1:0] act,
                               input logic [2*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: an operation accepted at clock n runs busy for W clocks,
    // publishes its product and pulses DONE at clock n+W+1
    always @(posedge CLK) begin
        int k_prev;
        int k;
        cyc++;
        if (RST) begin
            have_op  = 1'b0;
            exp_prod = '0;
            exp_busy = 1'b0;
            exp_done = 1'b0;
        end else begin
            k_prev = cyc - 1 - op_start;
            if (START && (!have_op || k_prev >= W + 1)) begin
                have_op  = 1'b1;
                op_start = cyc;
                pending  = refProduct(SGN, A, B);
            end
            k        = cyc - op_start;
            exp_busy = have_op && (k < W);
            exp_done = have_op && (k == W + 1);
            if (exp_done) exp_prod = pending;
        end
    end

    // Compare DUT outputs against the model on every falling edge
    always @(negedge CLK) begin
        if (check_en) begin
            checkOutput("busy", 64'(BUSY), 64'(exp_busy));
            checkOutput("done", 64'(DONE), 64'(exp_done));
            checkOutput("hi",   64'(HI),   64'(exp_prod[2*W-1:W]));
            checkOutput("lo",   64'(LO),   64'(exp_prod[W-1:0]));
        end
    end

    task automatic applyStimulus(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge CLK);
        START = 1'b1;
        SGN   = s;
        A     = a;
        B     = b;
        @(negedge CLK);
        START = 1'b0;
        SGN   = 1'($urandom);
        A     = $urandom;
        B     = $urandom;
    endtask

    task automatic waitDone(output int j, output int nb);
        j  = 0;
        nb = 0;
        while (j < 3 * W) begin
            if (BUSY === 1'b1) nb++;
            if (DONE === 1'b1) break;
            @(negedge CLK);
            j++;
        end
        if (DONE !== 1'b1) begin
            total++;
            bad++;
            $display("[TB] FAIL done_timeout: DONE=%b expected 1", DONE);
        end
    endtask

    initial begin
        int j;
        int nb;
        RST   = 1'b1;
        START = 1'b0;
        SGN   = 1'b0;
        A     = '0;
        B     = '0;
        repeat (2) @(negedge CLK);
        RST      = 1'b0;
        check_en = 1'b1;
        checkOutput("reset_prod", {HI, LO}, 64'h0);
        checkOutput("reset_busy", 64'(BUSY), 64'h0);
        checkOutput("reset_done", 64'(DONE), 64'h0);

        applyStimulus(1'b0, 32'd5, 32'd7);
        waitDone(j, nb);
        checkOutput("latency_5x7", 64'(j), 64'(W + 1));
        checkOutput("busy_len_5x7", 64'(nb), 64'(W));
        checkOutput("prod_5x7", {HI, LO}, 64'h0000_0000_0000_0023);

        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitDone(j, nb);
        checkOutput("prod_umax", {HI, LO}, 64'hFFFF_FFFE_0000_0001);

        applyStimulus(1'b1, 32'hFFFF_FFFD, 32'd4);
        waitDone(j, nb);
        checkOutput("prod_m3x4", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFF4);

        applyStimulus(1'b1, 32'h8000_0000, 32'h8000_0000);
        waitDone(j, nb);
        checkOutput("prod_smin_sq", {HI, LO}, 64'h4000_0000_0000_0000);

        applyStimulus(1'b0, 32'd100, 32'd200);
        repeat (5) @(negedge CLK);
        START = 1'b1;
        A     = 32'd7;
        B     = 32'd9;
        @(negedge CLK);
        START = 1'b0;
        waitDone(j, nb);
        checkOutput("prod_ignored_start", {HI, LO}, 64'd20000);

        applyStimulus(1'b0, 32'd11, 32'd13);
        waitDone(j, nb);
        checkOutput("prod_11x13", {HI, LO}, 64'd143);
        START = 1'b1;
        SGN   = 1'b0;
        A     = 32'd3;
        B     = 32'd4;
        @(negedge CLK);
        START = 1'b0;
        waitDone(j, nb);
        checkOutput("b2b_interval", 64'(j + 1), 64'(W + 2));
        checkOutput("prod_b2b_3x4", {HI, LO}, 64'd12);

        applyStimulus(1'b1, 32'd1234, 32'd5678);
        repeat (9) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checkOutput("midop_reset_prod", {HI, LO}, 64'h0);
        checkOutput("midop_reset_flags", {62'h0, BUSY, DONE}, 64'h0);

        applyStimulus(1'b1, 32'd6, 32'hFFFF_FFF9);
        waitDone(j, nb);
        checkOutput("prod_6xm7", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFD6);

        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                START = 1'b1;
                SGN   = 1'($urandom);
                A     = pickOperand();
                B     = pickOperand();
                @(negedge CLK);
                START = 1'b0;
                A     = $urandom;
                B     = $urandom;
            end else begin
                repeat ($urandom_range(0, 2)) @(negedge CLK);
                applyStimulus(1'($urandom), pickOperand(), pickOperand());
            end
            waitDone(j, nb);
        end

        repeat (3) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
